// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // FSM state encodings. The values are visible on the debug ports,
    // so they must not be renumbered.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_FAULT  = 4'd15;

    // IR[31:26] opcodes handled by DECODE.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that own a memory access and may stall on mem_ready.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the timeout limit is reached.
// Latency: expired is a combinational compare of the registered count (same cycle).
// Backpressure: none; count advances only while wait_en is high, clear has priority.
//
// Ports: clk/rst_n, clear (state change), wait_en (stalled in a memory state),
//        expired (count equals MEM_TIMEOUT; never set when MEM_TIMEOUT is 0).
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    // Saturate rather than wrap so a disabled timeout never produces a
    // misleading small count after a very long stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wait_en && (cnt != '1)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with memory-ready handshake, wait timeout to sticky FAULT, bne/addi.
// Latency: one state per clock; controls are Moore-decoded from state (FETCH IR/PC load gated by mem_ready).
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready=0; MEM_TIMEOUT consecutive waits -> FAULT until reset.
//
// Ports: opcode/zero/mem_ready in; datapath controls, pc_en, debug state/next_state,
//        illegal_op pulse, mem_fault. Optional MC_PERF_CNT_EN adds cycle_cnt/instr_cnt.
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic [3:0] state,
    output logic [3:0] next_state,
    output logic       illegal_op,
    output logic       mem_fault
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    logic expired;
    logic pc_write;
    logic pc_write_cond;
    logic is_bne;
    logic mem_hold;

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (next_state != state),
        .wait_en (is_mem_state(state) && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Stalled memory state: stay put unless the wait budget is used up.
    // mem_ready is checked first at each use site so a late completion wins.
    assign mem_hold = !mem_ready && expired;

    always_comb begin
        next_state = S_FETCH;
        illegal_op = 1'b0;
        case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : (mem_hold ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       next_state = S_EXEC;
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_J:           next_state = S_JUMP;
                    default: begin
                        // PC was already advanced in FETCH, so dropping
                        // back to FETCH retires the word as a NOP.
                        next_state = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : (mem_hold ? S_FAULT : S_MEMRD);
            S_MEMWR:  next_state = mem_ready ? S_FETCH : (mem_hold ? S_FAULT : S_MEMWR);
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_FAULT:  next_state = S_FAULT;
            // MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and unused codes 12-14.
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC only load on the cycle the fetch completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // bne takes the branch when the ALU difference is non-zero.
    assign is_bne    = (opcode == OP_BNE);
    assign pc_en     = pc_write | (pc_write_cond & (zero ^ is_bne));
    assign mem_fault = (state == S_FAULT);

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_FAULT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            // Covers normal retirement and the illegal-op DECODE->FETCH path.
            if ((next_state == S_FETCH) && (state != S_FETCH)) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
